rca: RTL and testbench

//   WIDTH-bit ripple-carry adder: Sum = A + B + C_in, carry-out on C_out.

---
 rtl/rca.sv | 48 ++++
 tb/tb_rca.sv | 115 +++++++++++
 2 files changed

// File: rtl/rca.sv
// WIDTH-bit ripple-carry adder built from a chain of full-adder cells.
// Combinational Sum/C_out plus a one-cycle registered copy with signed overflow.
module rca #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             C_in,
  output logic [WIDTH-1:0] Sum,
  output logic             C_out,
  output logic [WIDTH-1:0] Sum_r,
  output logic             C_out_r,
  output logic             ovf_r
);

  logic [WIDTH:0]   w_c;
  logic [WIDTH-1:0] w_s;
  logic             w_ovf;

  assign w_c[0] = C_in;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_fa
      assign w_s[gi]   = A[gi] ^ B[gi] ^ w_c[gi];
      assign w_c[gi+1] = (A[gi] & B[gi]) | (A[gi] & w_c[gi]) | (B[gi] & w_c[gi]);
    end
  endgenerate

  assign Sum   = w_s;
  assign C_out = w_c[WIDTH];
  // Carry into and out of the sign bit disagree exactly on signed overflow.
  assign w_ovf = w_c[WIDTH] ^ w_c[WIDTH-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Sum_r   <= '0;
      C_out_r <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      Sum_r   <= w_s;
      C_out_r <= w_c[WIDTH];
      ovf_r   <= w_ovf;
    end
  end

endmodule

// File: tb/tb_rca.sv
// Directed and exhaustive checks of the rca adder, combinational and registered paths.
module tb_rca;

  logic       clk;
  logic       rst;
  logic [3:0] A;
  logic [3:0] B;
  logic       C_in;
  logic [3:0] Sum;
  logic       C_out;
  logic [3:0] Sum_r;
  logic       C_out_r;
  logic       ovf_r;

  int errors = 0;
  int checks = 0;

  rca #(.WIDTH(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .A       (A),
    .B       (B),
    .C_in    (C_in),
    .Sum     (Sum),
    .C_out   (C_out),
    .Sum_r   (Sum_r),
    .C_out_r (C_out_r),
    .ovf_r   (ovf_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive operands, check the combinational result, then the registered copy after the edge.
  task automatic step(input string tag, input logic [3:0] a, input logic [3:0] b, input logic ci,
                      input logic [3:0] exp_s, input logic exp_c, input logic exp_v);
    @(negedge clk);
    A = a; B = b; C_in = ci;
    #1;
    check({tag, "_sum"}, {28'd0, Sum}, {28'd0, exp_s});
    check({tag, "_cout"}, {31'd0, C_out}, {31'd0, exp_c});
    @(posedge clk);
    #1;
    check({tag, "_sum_r"}, {28'd0, Sum_r}, {28'd0, exp_s});
    check({tag, "_cout_r"}, {31'd0, C_out_r}, {31'd0, exp_c});
    check({tag, "_ovf_r"}, {31'd0, ovf_r}, {31'd0, exp_v});
    $display("step %s: A=%b B=%b Cin=%b -> Sum=%b Cout=%b Sum_r=%b Cout_r=%b ovf_r=%b",
             tag, a, b, ci, Sum, C_out, Sum_r, C_out_r, ovf_r);
  endtask

  initial begin
    logic [4:0] full;
    logic [3:0] a4;
    logic [3:0] b4;
    logic       ci;
    logic       v;

    rst = 1'b1; A = 4'd0; B = 4'd0; C_in = 1'b0;
    @(posedge clk);
    #1;
    check("rst_sum_r", {28'd0, Sum_r}, 32'd0);
    check("rst_cout_r", {31'd0, C_out_r}, 32'd0);
    check("rst_ovf_r", {31'd0, ovf_r}, 32'd0);
    check("rst_sum_comb", {28'd0, Sum}, 32'd0);
    check("rst_cout_comb", {31'd0, C_out}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    step("zero",     4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0);
    step("e_plus_1", 4'b1110, 4'b0001, 1'b0, 4'b1111, 1'b0, 1'b0);
    step("m8_m1",    4'b1000, 4'b1111, 1'b0, 4'b0111, 1'b1, 1'b1);
    step("m5_m7",    4'b1011, 4'b1001, 1'b0, 4'b0100, 1'b1, 1'b1);
    step("1_plus_5", 4'b0001, 4'b0101, 1'b0, 4'b0110, 1'b0, 1'b0);
    step("ripple",   4'b1111, 4'b0000, 1'b1, 4'b0000, 1'b1, 1'b0);
    step("7_plus_1", 4'b0111, 4'b0001, 1'b0, 4'b1000, 1'b0, 1'b1);

    // Registers now hold Sum_r=1000, ovf_r=1; pulse reset between edges.
    #1;
    rst = 1'b1;
    #1;
    check("mid_rst_sum_r", {28'd0, Sum_r}, 32'd0);
    check("mid_rst_cout_r", {31'd0, C_out_r}, 32'd0);
    check("mid_rst_ovf_r", {31'd0, ovf_r}, 32'd0);
    check("mid_rst_sum", {28'd0, Sum}, 32'h8);
    check("mid_rst_cout", {31'd0, C_out}, 32'd0);
    $display("mid-stream reset: Sum_r=%b C_out_r=%b ovf_r=%b Sum=%b", Sum_r, C_out_r, ovf_r, Sum);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_sum_r", {28'd0, Sum_r}, 32'h8);
    check("post_rst_ovf_r", {31'd0, ovf_r}, 32'd1);

    for (int i = 0; i < 512; i++) begin
      a4 = i[3:0];
      b4 = i[7:4];
      ci = i[8];
      full = {1'b0, a4} + {1'b0, b4} + {4'd0, ci};
      v = (a4[3] == b4[3]) && (full[3] != a4[3]);
      step($sformatf("sweep%0d", i), a4, b4, ci, full[3:0], full[4], v);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
